// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC serial capture block: FSM states, the
// synchroniser floor and the one-hot channel rotate helper.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int MAX_CH          = 8;

    // Rotate a one-hot vector left by one position within the low n bits.
    function automatic logic [MAX_CH-1:0] rotate_onehot(input logic [MAX_CH-1:0] v,
                                                        input int unsigned     n);
        logic [MAX_CH-1:0] mask;
        mask = (MAX_CH'(1) << n) - MAX_CH'(1);
        return ((v << 1) & mask) | ((v >> (n - 1)) & MAX_CH'(1));
    endfunction

endpackage

// File: rtl/adc_capture_fifo.sv
// Two-entry valid/ready buffer. Head is registered and held until popped;
// a push and a pop in the same cycle are both accepted even when full.
module adc_capture_fifo #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_ready,
    output logic [W-1:0] head,
    output logic         head_valid,
    output logic         full
);

    logic [W-1:0] tail;
    logic         tail_valid;
    logic         pop;

    assign pop  = head_valid & pop_ready;
    assign full = head_valid & tail_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head       <= '0;
            tail       <= '0;
            head_valid <= 1'b0;
            tail_valid <= 1'b0;
        end else if (pop) begin
            if (tail_valid) begin
                head <= tail;
                if (push) tail <= push_data;
                else      tail_valid <= 1'b0;
            end else begin
                if (push) head <= push_data;
                else      head_valid <= 1'b0;
            end
        end else if (push) begin
            if (!head_valid) begin
                head       <= push_data;
                head_valid <= 1'b1;
            end else if (!tail_valid) begin
                tail       <= push_data;
                tail_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_capture_mux.sv
// Multi-channel ADC serial receiver: oversamples drdyn/dclk/dout, deserialises
// one word per frame and tags it with the round-robin channel. Optional
// mid-frame dclk watchdog enabled by ADC_CAPTURE_TIMEOUT_EN.
module adc_capture_mux
    import adc_capture_pkg::*;
#(
    parameter  int NUM_CH      = 2,
    parameter  int DATA_W      = 24,
    parameter  int SYNC_STAGES = 2,
    parameter  int TIMEOUT     = 1023,
    localparam int CH_W        = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              drdyn,
    input  logic              dclk,
    input  logic              dout,
    output logic [NUM_CH-1:0] sel,
    output logic [DATA_W-1:0] data,
    output logic [CH_W-1:0]   data_ch,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              frame_err,
    output logic              ovr,
    input  logic              ovr_clr
);

    localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
    localparam int CNT_W  = $clog2(DATA_W + 1);

    logic [SYNC_N-1:0]      drdyn_sync, dclk_sync, dout_sync;
    logic                   drdyn_s, dclk_s, dout_s;
    logic                   drdyn_prev, dclk_prev;
    logic                   drdyn_fall, dclk_rise;
    state_t                 state;
    logic [DATA_W-1:0]      shreg;
    logic [CNT_W-1:0]       bit_cnt;
    logic [CH_W-1:0]        tag, sel_idx;
    logic [NUM_CH-1:0]      sel_next;
    logic                   timed_out, full, pop, push, overrun;
    logic [DATA_W+CH_W-1:0] head;

    assign drdyn_s    = drdyn_sync[SYNC_N-1];
    assign dclk_s     = dclk_sync[SYNC_N-1];
    assign dout_s     = dout_sync[SYNC_N-1];
    assign drdyn_fall = drdyn_prev & ~drdyn_s;
    assign dclk_rise  = dclk_s & ~dclk_prev;

    // Idle levels: drdyn deasserted (high), dclk/dout low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drdyn_sync <= '1;
            dclk_sync  <= '0;
            dout_sync  <= '0;
            drdyn_prev <= 1'b1;
            dclk_prev  <= 1'b0;
        end else begin
            drdyn_sync <= {drdyn_sync[SYNC_N-2:0], drdyn};
            dclk_sync  <= {dclk_sync[SYNC_N-2:0], dclk};
            dout_sync  <= {dout_sync[SYNC_N-2:0], dout};
            drdyn_prev <= drdyn_s;
            dclk_prev  <= dclk_s;
        end
    end

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel[i]) sel_idx = CH_W'(i);
        end
    end

    assign sel_next = NUM_CH'(rotate_onehot(MAX_CH'(sel), NUM_CH));

`ifdef ADC_CAPTURE_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd;

    // Watchdog restarts on every dclk rising edge and only runs mid-frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                              wd <= '0;
        else if (state != ST_SHIFT || dclk_rise) wd <= '0;
        else if (!timed_out)                    wd <= wd + WD_W'(1);
    end

    assign timed_out = (state == ST_SHIFT) && (wd == WD_W'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    // A full buffer only drops the word when the consumer is not popping this cycle.
    assign pop     = data_valid & data_ready;
    assign overrun = (state == ST_DONE) && full && !pop;
    assign push    = (state == ST_DONE) && !overrun;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            tag       <= '0;
            sel       <= NUM_CH'(1);
            frame_err <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (overrun)      ovr <= 1'b1;
            else if (ovr_clr) ovr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (drdyn_fall) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                        tag     <= sel_idx;
                    end
                end
                ST_SHIFT: begin
                    if (dclk_rise) begin
                        shreg   <= {shreg[DATA_W-2:0], dout_s};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(DATA_W - 1)) state <= ST_DONE;
                    end else if (drdyn_s || timed_out) begin
                        state     <= ST_IDLE;
                        frame_err <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    sel   <= sel_next;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    adc_capture_fifo #(.W(DATA_W + CH_W)) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (push),
        .push_data  ({shreg, tag}),
        .pop_ready  (data_ready),
        .head       (head),
        .head_valid (data_valid),
        .full       (full)
    );

    assign data    = head[DATA_W+CH_W-1:CH_W];
    assign data_ch = head[CH_W-1:0];

endmodule
